// File: rtl/quad_decoder_counter_if.sv
// -----------------------------------------------------------------------------
// quad_decoder_counter_if
//   Groups the encoder pins, the load/clear controls and the position outputs
//   of quad_decoder_counter into one bundle. clk and rst are not part of it.
//
//   Signals
//     a_in, b_in : quadrature channels A/B (asynchronous to clk)
//     load, d_in : synchronous load strobe and load value
//     clr_err    : synchronous clear of the sticky err flag
//     count      : current position
//     dir        : direction of the last legal step (1 = up, 0 = down)
//     step, wrap : one-cycle pulses after a decoded step / a wrapping step
//     err        : sticky illegal-transition flag
//
//   Modports
//     master : the side driving pins and controls (datapath / testbench)
//     slave  : the decoder/counter itself
// -----------------------------------------------------------------------------
interface quad_decoder_counter_if #(
    parameter int WIDTH = 8
);
    logic             a_in;
    logic             b_in;
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic             clr_err;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             wrap;
    logic             err;

    modport master (
        output a_in, b_in, load, d_in, clr_err,
        input  count, dir, step, wrap, err
    );

    modport slave (
        input  a_in, b_in, load, d_in, clr_err,
        output count, dir, step, wrap, err
    );
endinterface

// File: rtl/quad_decoder_counter.sv
// -----------------------------------------------------------------------------
// quad_decoder_counter
//   x4 quadrature (A/B) decoder driving a loadable up/down position counter
//   that wraps at both ends. Every legal edge on A or B moves the count by one;
//   a sample where both A and B changed is flagged in a sticky err bit.
//
//   Parameters
//     WIDTH       : width of the position counter and load data
//     SYNC_STAGES : synchronizer flops per quadrature input (2..4)
//
//   Ports
//     clk : clock, all state updates on the rising edge
//     rst : asynchronous, active-high reset
//     bus : quad_decoder_counter_if.slave
//             in : a_in, b_in, load, d_in, clr_err
//             out: count, dir, step, wrap, err
//
//   Timing: a pin edge captured at clock edge k is decoded at edge
//   k+SYNC_STAGES; step/wrap are high in the cycle following that edge.
// -----------------------------------------------------------------------------
module quad_decoder_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_decoder_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
    // INIT spans SYNC_STAGES+1 edges: the counter runs 0..SYNC_STAGES.
    localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES);

    // -------------------------------------------------------------------------
    // Input synchronizers, one flop chain per channel.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic r_a;
            logic r_b;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= 1'b0;
                        r_b <= 1'b0;
                    end else begin
                        r_a <= bus.a_in;
                        r_b <= bus.b_in;
                    end
                end
            end else begin : g_chain
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= 1'b0;
                        r_b <= 1'b0;
                    end else begin
                        r_a <= g_sync[gi-1].r_a;
                        r_b <= g_sync[gi-1].r_b;
                    end
                end
            end
        end
    endgenerate

    logic [1:0] w_ab_s;
    assign w_ab_s = {g_sync[SYNC_STAGES-1].r_a, g_sync[SYNC_STAGES-1].r_b};

    // -------------------------------------------------------------------------
    // Start-up FSM. INIT lets the synchronizers fill with the real pin levels
    // (and prev_ab follow them) before any transition is interpreted, so pins
    // resting at a non-00 level across reset do not look like motion.
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_init_cnt;
    logic [2:0] w_init_cnt_next;
    logic       w_decode_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        w_decode_en     = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_init_cnt_next = r_init_cnt + 3'd1;
                end
            end
            ST_RUN: begin
                w_decode_en = 1'b1;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transition decode on (prev_ab, ab_s).
    // -------------------------------------------------------------------------
    logic [1:0] r_prev_ab;
    logic       w_pat_up;
    logic       w_pat_dn;
    logic       w_step_up;
    logic       w_step_dn;
    logic       w_illegal;

    always_comb begin
        w_pat_up = 1'b0;
        w_pat_dn = 1'b0;
        case ({r_prev_ab, w_ab_s})
            // A leads B: 00->10->11->01->00
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_pat_up = 1'b1;
            // B leads A: 00->01->11->10->00
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_pat_dn = 1'b1;
            default: begin
                w_pat_up = 1'b0;
                w_pat_dn = 1'b0;
            end
        endcase
    end

    assign w_step_up = w_decode_en & w_pat_up;
    assign w_step_dn = w_decode_en & w_pat_dn;
    // Both bits flipping between two samples means an edge was missed.
    assign w_illegal = w_decode_en & ((w_ab_s ^ r_prev_ab) == 2'b11);

    // -------------------------------------------------------------------------
    // Position counter and status outputs.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_step;
    logic             r_wrap;
    logic             r_err;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (r_count == ALL_ONES);
    assign w_at_zero = (r_count == ALL_ZEROS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_ab <= 2'b00;
            r_count   <= ALL_ZEROS;
            r_dir     <= 1'b1;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // prev_ab tracks every cycle, so a step overridden by load is
            // dropped, not replayed later.
            r_prev_ab <= w_ab_s;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;

            if (bus.load) begin
                r_count <= bus.d_in;
            end else if (w_step_up) begin
                r_count <= w_at_max ? ALL_ZEROS : (r_count + ONE);
                r_wrap  <= w_at_max;
                r_step  <= 1'b1;
                r_dir   <= 1'b1;
            end else if (w_step_dn) begin
                r_count <= w_at_zero ? ALL_ONES : (r_count - ONE);
                r_wrap  <= w_at_zero;
                r_step  <= 1'b1;
                r_dir   <= 1'b0;
            end

            // A new illegal transition outranks a simultaneous clear.
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.dir   = r_dir;
    assign bus.step  = r_step;
    assign bus.wrap  = r_wrap;
    assign bus.err   = r_err;

endmodule

// File: doc/quad_decoder_counter.md
Name: quad_decoder_counter

Overview:
- Quadrature (A/B) decoder feeding a loadable up/down position counter with wrap-around.
- Sits between external incremental-encoder pins and the datapath. It generates the count-up/count-down decisions itself instead of taking them from a control input.
- Decoding is x4: every legal edge on A or B moves the count by exactly one.

Parameters:
- WIDTH, 8: width of the position counter and the load data.
- SYNC_STAGES, 2: synchronizer flops per quadrature input; legal range 2..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_in  input  1  quadrature channel A; asynchronous to clk.
- b_in  input  1  quadrature channel B; asynchronous to clk.
- load  input  1  synchronous load strobe, active high.
- d_in  input  WIDTH  value written to count when load=1.
- clr_err  input  1  synchronous clear of the sticky err flag.
- count  output  WIDTH  current position.
- dir  output  1  direction of the last legal step: 1 = up, 0 = down.
- step  output  1  one-cycle pulse, high in the cycle after count changed by a decoded step.
- wrap  output  1  one-cycle pulse, high when that step wrapped (max→0 or 0→max).
- err  output  1  sticky flag: illegal transition seen (A and B changed in the same sample).

Behaviour:
- Reset (async assert): count=0, dir=1, step=0, wrap=0, err=0, all synchronizer flops=0, prev_ab=00, FSM=INIT.
- Synchronizer: a_in and b_in each pass through SYNC_STAGES flops. The last stage is ab_s[1:0] = {A,B}.
- FSM INIT:
  - Counts SYNC_STAGES+1 clocks after reset release while prev_ab <= ab_s every cycle.
  - No decoding, no err, no step during INIT; load is honoured.
  - This prevents a spurious step or err when the pins sit at a non-00 level at reset.
  - Then moves to RUN.
- FSM RUN: each cycle prev_ab <= ab_s, and the pair (prev_ab, ab_s) is decoded:
  - Up (A leads B): 00→10, 10→11, 11→01, 01→00.
  - Down: 00→01, 01→11, 11→10, 10→00.
  - Unchanged: no action.
  - Both bits changed: illegal. Set err; count and dir unchanged; no step.
- Counting:
  - Up: count == 2^WIDTH-1 → 0 with wrap=1; otherwise count+1.
  - Down: count == 0 → 2^WIDTH-1 with wrap=1; otherwise count-1.
  - On every legal step, dir is set to the step direction and step=1 for one cycle.
- Latency: an A/B edge that meets setup before clock edge k changes count on edge k+SYNC_STAGES (SYNC_STAGES+1 edges counting edge k). step and wrap are high in the cycle following that edge.
- Priority, highest first: rst > load > decoded step.
- load in RUN with a legal step in the same cycle:
  - count <= d_in; the step is discarded (step=0, wrap=0, dir unchanged).
  - prev_ab still updates, so the step is lost rather than deferred.
- err handling:
  - clr_err=1 clears err on the next edge.
  - An illegal transition in the same cycle as clr_err leaves err=1 (set wins).
  - err does not block counting.
- Max input rate: A/B must hold each state at least 2 clk periods. Faster inputs are reported as illegal transitions when edges collapse into one sample.
- Async reset mid-operation: everything returns to reset values immediately and the FSM re-enters INIT.

Test Plan:
- Reset release with a_in=b_in=1 held, no motion for 10 cycles → count=0, step never pulses, err=0.
- WIDTH=8, load d_in=0xFD, then 4 up quarter-steps (00→10→11→01→00), each held 4 clks → count 0xFE, 0xFF, 0x00, 0x01; wrap pulses only on 0xFF→0x00; dir=1; exactly 4 step pulses; first change 3 edges after the first A edge.
- From count=0x01, 2 down steps → 0x00, then 0xFF with wrap=1; dir=0.
- Drive AB 00→11 in one cycle → err=1, count unchanged, no step. Next cycle clr_err=1 → err=0. clr_err coincident with another 11→00 jump → err stays 1.
- load d_in=0x40 in the exact cycle a legal up step is decoded → count=0x40, step=0, dir unchanged. The next legal up step gives 0x41.
- Assert rst asynchronously mid-rotation (between clock edges) → count=0 and err=0 immediately. Pins held at 10 through INIT produce no step; the next legal step is counted.
